prng64_seed_consumer: RTL and testbench
=======================================

Name: prng64_seed_consumer

Overview:
Receiving end of the ADC seed path. Samples the 2x32-bit seed words, health-checks them, loads a 64-bit xorshift generator and streams 64-bit random words over a valid/ready interface. Exports generator state on seedloop, closing the loop back to the seed generator. Reseeds periodically or on request.

Parameters:
RESEED_INTERVAL, 1024, accepted output words between automatic reseeds (>=1)
WARMUP_CYCLES, 16, generator steps discarded after each load (>=1)
REP_LIMIT, 3, consecutive rejected seeds before sticky failure (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
seed1  in  32  upper seed word
seed2  in  32  lower seed word
seed_valid  in  1  seed words valid this cycle (tie high if free-running)
reseed_req  in  1  single-cycle request to reseed
rand_out  out  64  random word (= generator state)
rand_valid  out  1  rand_out valid
rand_ready  in  1  consumer accepts rand_out
seedloop  out  64  generator state fed back to the seed generator
busy  out  1  high while in CAPTURE/CHECK/WARMUP
health_fail  out  1  sticky; set on REP_LIMIT consecutive rejects
reseed_count  out  16  completed successful loads, saturating at 16'hFFFF

Behaviour:
- Reset values: state register 0, so rand_out = seedloop = 0; rand_valid 0; busy 1; health_fail 0; reseed_count 0; prev_seed 0; fail_cnt 0; word counter 0; FSM = CAPTURE.
- Seed word: cand = {seed1, seed2}. Load value: mixed = cand ^ 64'h9E3779B97F4A7C15.
- Step function: x ^= x<<13; x ^= x>>7; x ^= x<<17. All shifts are 64-bit and discard overflow.
- CAPTURE: if seed_valid, latch cand and go to CHECK; otherwise stay.
- CHECK (1 cycle): reject if cand == 0, cand == prev_seed, or mixed == 0.
  - Accept: state <= mixed; prev_seed <= cand; fail_cnt <= 0; reseed_count++ (saturating); warm counter <= 0; go to WARMUP.
  - Reject: fail_cnt++. If new fail_cnt == REP_LIMIT, set health_fail and go to FAIL. Otherwise go to CAPTURE. State register is unchanged.
- WARMUP: step the state every cycle for exactly WARMUP_CYCLES cycles, then go to RUN with word counter cleared. rand_valid stays 0.
- RUN: rand_valid = 1, busy = 0. On rand_valid && rand_ready, state steps on that edge and word counter++. When the counter reaches RESEED_INTERVAL on an accept, go to CAPTURE; the accepted word is the last word of that epoch.
- reseed_req in RUN: go to CAPTURE next cycle; rand_valid drops the same edge. If reseed_req and a handshake coincide, the handshake completes (state steps) and then the FSM reseeds. reseed_req outside RUN is ignored.
- FAIL: terminal until rst. rand_valid 0, busy 0, state frozen, health_fail 1.
- Latency: with seed_valid high, rand_valid rises WARMUP_CYCLES+2 cycles after the CAPTURE cycle.
- rand_out is stable while rand_valid && !rand_ready.
- seedloop always equals the state register, including during WARMUP.
- rst asserted in any state, mid-warmup or mid-handshake: everything returns to reset values on the next edge. health_fail clears only on rst.

Decomposition:
- Package prng64_pkg holds:
  - FSM state enum: CAPTURE, CHECK, WARMUP, RUN, FAIL.
  - Mix constant 64'h9E3779B97F4A7C15.
  - Shift constants 13/7/17.
  - Counter widths derived via $clog2.
- One combinational sub-module, xorshift64_step (in 64, out 64). It is shared by WARMUP and RUN and reused by the bench model.

Test Plan:
- Defaults, seed1=32'hDEADBEEF, seed2=32'h01234567, seed_valid=1, rand_ready=1 -> rand_valid rises 18 cycles after CAPTURE; first rand_out equals the model's 16-step xorshift of 64'hDEADBEEF01234567^mix; busy falls the same cycle; reseed_count=1.
- seed1=seed2=0 held, REP_LIMIT=3 -> three CAPTURE/CHECK rejects; health_fail=1 at the third CHECK edge; rand_valid stays 0 and state stays 0 until rst.
- rand_ready held low for 10 cycles in RUN -> rand_out constant; then ready for 1 cycle -> exactly one step, word counter = 1.
- RESEED_INTERVAL=4, seeds changing each cycle -> after the 4th accept rand_valid drops the next cycle; reseed_count reaches 2 and prev_seed updates.
- reseed_req pulsed together with a handshake -> word counted, state stepped once, FSM enters CAPTURE; repeating the identical seed is rejected once (fail_cnt=1), then a new seed is accepted.
- rst asserted mid-WARMUP (cycle 5 of 16) -> next edge state=0, busy=1, reseed_count=0, FSM=CAPTURE.

Source files
------------

// File: rtl/prng64_pkg.sv
// Shared types and constants for the seeded 64-bit xorshift generator.
package prng64_pkg;

  typedef enum logic [2:0] {
    CAPTURE = 3'd0,
    CHECK   = 3'd1,
    WARMUP  = 3'd2,
    RUN     = 3'd3,
    FAIL    = 3'd4
  } fsm_e;

  localparam logic [63:0] MIX_CONST = 64'h9E3779B97F4A7C15;

  localparam int SH_A = 13;
  localparam int SH_B = 7;
  localparam int SH_C = 17;

  // Bits needed to hold values 0..n.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/xorshift64_step.sv
// One combinational xorshift64 step: x ^= x<<13; x ^= x>>7; x ^= x<<17.
module xorshift64_step
  import prng64_pkg::*;
(
  input  logic [63:0] x,
  output logic [63:0] y
);

  logic [63:0] a, b;

  assign a = x ^ (x << SH_A);
  assign b = a ^ (a >> SH_B);
  assign y = b ^ (b << SH_C);

endmodule

// File: rtl/prng64_seed_consumer.sv
// Seed capture, health check, warmup and valid/ready streaming of a 64-bit
// xorshift generator; the generator state is looped back on seedloop.
module prng64_seed_consumer
  import prng64_pkg::*;
#(
  parameter int RESEED_INTERVAL = 1024,
  parameter int WARMUP_CYCLES   = 16,
  parameter int REP_LIMIT       = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] seed1,
  input  logic [31:0] seed2,
  input  logic        seed_valid,
  input  logic        reseed_req,
  output logic [63:0] rand_out,
  output logic        rand_valid,
  input  logic        rand_ready,
  output logic [63:0] seedloop,
  output logic        busy,
  output logic        health_fail,
  output logic [15:0] reseed_count
);

  localparam int WW = cnt_w(RESEED_INTERVAL);
  localparam int MW = cnt_w(WARMUP_CYCLES);
  localparam int FW = cnt_w(REP_LIMIT);

  fsm_e          fsm;
  logic [63:0]   x, x_nxt, cand_q, prev_seed, mixed;
  logic [WW-1:0] word_cnt;
  logic [MW-1:0] warm_cnt;
  logic [FW-1:0] fail_cnt;
  logic          seed_ok;

  xorshift64_step u_step (.x(x), .y(x_nxt));

  assign mixed   = cand_q ^ MIX_CONST;
  assign seed_ok = (cand_q != '0) && (cand_q != prev_seed) && (mixed != '0);

  assign rand_out   = x;
  assign seedloop   = x;
  assign rand_valid = (fsm == RUN);
  assign busy       = (fsm == CAPTURE) || (fsm == CHECK) || (fsm == WARMUP);

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm          <= CAPTURE;
      x            <= '0;
      cand_q       <= '0;
      prev_seed    <= '0;
      word_cnt     <= '0;
      warm_cnt     <= '0;
      fail_cnt     <= '0;
      health_fail  <= 1'b0;
      reseed_count <= '0;
    end else begin
      case (fsm)
        CAPTURE: begin
          if (seed_valid) begin
            cand_q <= {seed1, seed2};
            fsm    <= CHECK;
          end
        end
        CHECK: begin
          if (seed_ok) begin
            x         <= mixed;
            prev_seed <= cand_q;
            fail_cnt  <= '0;
            warm_cnt  <= '0;
            if (reseed_count != 16'hFFFF) reseed_count <= reseed_count + 16'd1;
            fsm       <= WARMUP;
          end else begin
            fail_cnt <= fail_cnt + 1'b1;
            // Compare against the pre-increment value: this reject is the last allowed.
            if (fail_cnt == FW'(REP_LIMIT - 1)) begin
              health_fail <= 1'b1;
              fsm         <= FAIL;
            end else begin
              fsm <= CAPTURE;
            end
          end
        end
        WARMUP: begin
          x <= x_nxt;
          if (warm_cnt == MW'(WARMUP_CYCLES - 1)) begin
            word_cnt <= '0;
            fsm      <= RUN;
          end else begin
            warm_cnt <= warm_cnt + 1'b1;
          end
        end
        RUN: begin
          if (rand_ready) begin
            x        <= x_nxt;
            word_cnt <= word_cnt + 1'b1;
            if (word_cnt == WW'(RESEED_INTERVAL - 1)) fsm <= CAPTURE;
          end
          // A coinciding handshake still completes above before reseeding.
          if (reseed_req) fsm <= CAPTURE;
        end
        FAIL: ;
        default: fsm <= CAPTURE;
      endcase
    end
  end

endmodule

// File: tb/tb_prng64_seed_consumer.sv
// Directed bench for prng64_seed_consumer with a short reseed interval.
module tb_prng64_seed_consumer;

  localparam logic [63:0] MIX = 64'h9E3779B97F4A7C15;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] seed1, seed2;
  logic        seed_valid, reseed_req, rand_ready;
  logic [63:0] rand_out, seedloop;
  logic        rand_valid, busy, health_fail;
  logic [15:0] reseed_count;

  int checks = 0;
  int errors = 0;
  logic [63:0] v1, v2;

  always #5 clk = ~clk;

  prng64_seed_consumer #(.RESEED_INTERVAL(4), .WARMUP_CYCLES(16), .REP_LIMIT(3)) dut (
    .clk(clk), .rst(rst), .seed1(seed1), .seed2(seed2), .seed_valid(seed_valid),
    .reseed_req(reseed_req), .rand_out(rand_out), .rand_valid(rand_valid),
    .rand_ready(rand_ready), .seedloop(seedloop), .busy(busy),
    .health_fail(health_fail), .reseed_count(reseed_count)
  );

  function automatic logic [63:0] mstep(input logic [63:0] v);
    logic [63:0] t;
    t = v;
    t = t ^ (t << 13);
    t = t ^ (t >> 7);
    t = t ^ (t << 17);
    return t;
  endfunction

  function automatic logic [63:0] mwarm(input logic [63:0] cand, input int n);
    logic [63:0] t;
    t = cand ^ MIX;
    for (int i = 0; i < n; i++) t = mstep(t);
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; seed_valid = 1'b0; reseed_req = 1'b0; rand_ready = 1'b0;
    seed1 = '0; seed2 = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++;
    if (rand_out !== 64'd0 || seedloop !== 64'd0) begin
      errors++; $display("FAIL reset_state rand_out=%h seedloop=%h exp 0", rand_out, seedloop);
    end
    checks++;
    if ({rand_valid, busy, health_fail} !== 3'b010) begin
      errors++; $display("FAIL reset_flags valid/busy/hf=%b exp 010", {rand_valid, busy, health_fail});
    end
    checks++;
    if (reseed_count !== 16'd0) begin
      errors++; $display("FAIL reset_count got %0d exp 0", reseed_count);
    end
  endtask

  task automatic test_latency();
    int n;
    logic [63:0] c;
    c = 64'hDEADBEEF01234567;
    {seed1, seed2} = c; seed_valid = 1'b1; rand_ready = 1'b1;
    n = 0;
    while (!rand_valid && n < 100) begin tick(); n++; end
    rand_ready = 1'b0;
    v1 = mwarm(c, 16);
    checks++;
    if (n !== 18) begin errors++; $display("FAIL latency got %0d exp 18", n); end
    checks++;
    if (rand_out !== v1 || seedloop !== v1) begin
      errors++; $display("FAIL first_word got %h/%h exp %h", rand_out, seedloop, v1);
    end
    checks++;
    if (busy !== 1'b0 || reseed_count !== 16'd1) begin
      errors++; $display("FAIL first_busy_count busy=%b cnt=%0d exp 0/1", busy, reseed_count);
    end
  endtask

  task automatic test_ready_hold();
    rand_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (rand_out !== v1 || rand_valid !== 1'b1) begin
        errors++; $display("FAIL hold_%0d rand_out=%h valid=%b exp %h/1", i, rand_out, rand_valid, v1);
      end
    end
    rand_ready = 1'b1;
    tick();
    rand_ready = 1'b0;
    checks++;
    if (rand_out !== mstep(v1)) begin
      errors++; $display("FAIL single_step got %h exp %h", rand_out, mstep(v1));
    end
    tick();
    checks++;
    if (rand_out !== mstep(v1) || rand_valid !== 1'b1) begin
      errors++; $display("FAIL one_step_only got %h valid=%b exp %h/1", rand_out, rand_valid, mstep(v1));
    end
  endtask

  task automatic test_interval();
    logic [63:0] e, c;
    int n;
    e = mstep(v1);
    rand_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      e = mstep(e);
      checks++;
      if (rand_out !== e || rand_valid !== (k < 3) || busy !== (k == 3)) begin
        errors++; $display("FAIL interval_acc%0d out=%h valid=%b busy=%b exp %h", k + 1, rand_out, rand_valid, busy, e);
      end
    end
    c = 64'h1111111122222222;
    {seed1, seed2} = c;
    n = 0;
    while (!rand_valid && n < 100) begin
      tick(); n++;
      seed1 = 32'hA5A50000 + n; seed2 = 32'h5A5A0000 ^ n;
    end
    rand_ready = 1'b0;
    {seed1, seed2} = c;
    v2 = mwarm(c, 16);
    checks++;
    if (n !== 18 || rand_out !== v2) begin
      errors++; $display("FAIL reseed_epoch n=%0d out=%h exp 18/%h", n, rand_out, v2);
    end
    checks++;
    if (reseed_count !== 16'd2) begin errors++; $display("FAIL reseed_count2 got %0d exp 2", reseed_count); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] c;
    int n;
    rand_ready = 1'b1; reseed_req = 1'b1;
    tick();
    rand_ready = 1'b0; reseed_req = 1'b0;
    checks++;
    if (rand_valid !== 1'b0 || busy !== 1'b1 || rand_out !== mstep(v2)) begin
      errors++; $display("FAIL reseed_hs valid=%b busy=%b out=%h exp 0/1/%h", rand_valid, busy, rand_out, mstep(v2));
    end
    tick();
    c = 64'hCAFEF00D12345678;
    {seed1, seed2} = c;
    tick();
    checks++;
    if (rand_out !== mstep(v2) || reseed_count !== 16'd2 || busy !== 1'b1) begin
      errors++; $display("FAIL repeat_reject out=%h cnt=%0d busy=%b exp %h/2/1", rand_out, reseed_count, busy, mstep(v2));
    end
    n = 0;
    while (!rand_valid && n < 100) begin tick(); n++; end
    checks++;
    if (n !== 18 || rand_out !== mwarm(c, 16) || reseed_count !== 16'd3) begin
      errors++; $display("FAIL new_seed_accept n=%0d out=%h cnt=%0d exp 18/%h/3", n, rand_out, reseed_count, mwarm(c, 16));
    end
  endtask

  task automatic test_rst_warmup();
    logic [63:0] c;
    int n;
    c = 64'h0A0B0C0D01020304;
    {seed1, seed2} = c; reseed_req = 1'b1;
    tick();
    reseed_req = 1'b0;
    tick(); tick();
    checks++;
    if (seedloop !== mwarm(c, 0)) begin
      errors++; $display("FAIL warm_load got %h exp %h", seedloop, mwarm(c, 0));
    end
    repeat (5) tick();
    checks++;
    if (seedloop !== mwarm(c, 5) || busy !== 1'b1 || rand_valid !== 1'b0) begin
      errors++; $display("FAIL warm5 got %h busy=%b valid=%b exp %h/1/0", seedloop, busy, rand_valid, mwarm(c, 5));
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (rand_out !== 64'd0 || {rand_valid, busy, health_fail} !== 3'b010 || reseed_count !== 16'd0) begin
      errors++; $display("FAIL rst_mid_warm out=%h flags=%b cnt=%0d exp 0/010/0", rand_out, {rand_valid, busy, health_fail}, reseed_count);
    end
    n = 0;
    while (!rand_valid && n < 100) begin tick(); n++; end
    checks++;
    if (n !== 18 || rand_out !== mwarm(c, 16) || reseed_count !== 16'd1) begin
      errors++; $display("FAIL post_rst_load n=%0d out=%h cnt=%0d exp 18/%h/1", n, rand_out, reseed_count, mwarm(c, 16));
    end
  endtask

  task automatic test_health_fail();
    logic [63:0] m;
    m = MIX;
    rst = 1'b1; tick(); rst = 1'b0;
    {seed1, seed2} = 64'd0; seed_valid = 1'b1; rand_ready = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == 2) {seed1, seed2} = m;
      if (e == 4) {seed1, seed2} = 64'd0;
      checks++;
      if (health_fail !== (e == 6) || rand_out !== 64'd0 || rand_valid !== 1'b0) begin
        errors++; $display("FAIL reject_edge%0d hf=%b out=%h valid=%b exp %b/0/0", e, health_fail, rand_out, rand_valid, e == 6);
      end
    end
    checks++;
    if (busy !== 1'b0 || reseed_count !== 16'd0) begin
      errors++; $display("FAIL fail_state busy=%b cnt=%0d exp 0/0", busy, reseed_count);
    end
    {seed1, seed2} = 64'hDEADBEEF01234567;
    for (int i = 0; i < 30; i++) begin
      reseed_req = i[0];
      tick();
    end
    reseed_req = 1'b0;
    checks++;
    if ({health_fail, rand_valid, busy} !== 3'b100 || rand_out !== 64'd0) begin
      errors++; $display("FAIL fail_sticky flags=%b out=%h exp 100/0", {health_fail, rand_valid, busy}, rand_out);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if (health_fail !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL fail_clear hf=%b busy=%b exp 0/1", health_fail, busy);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_ready_hold();
    test_interval();
    test_back_to_back();
    test_rst_warmup();
    test_health_fail();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
